// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble/SFD, CRC-32 FCS, inter-frame gap and underrun signalling.
// Short-frame zero padding is compiled in only when TX_PAD_EN is defined.
module gmii_tx_mac #(
    parameter int PREAM_LEN = 7,
    parameter int IFG_LEN   = 12,
    parameter int MIN_LEN   = 60
) (
    input  logic       phy_gtx_clk,
    input  logic       sys_rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic [7:0] phy_txd,
    output logic       frame_done,
    output logic       underrun
);
`ifdef TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREAM = 3'd1,
        SFD   = 3'd2,
        DATA  = 3'd3,
        PAD   = 3'd4,
        FCS   = 3'd5,
        IFG   = 3'd6
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [15:0] byte_cnt, byte_cnt_nx, byte_inc;
    logic [31:0] crc, crc_nx;
    logic        tx_en_nx, tx_er_nx, done_nx, under_nx;
    logic [7:0]  txd_nx;

    // Reflected CRC-32 (poly 0x04C11DB7 as 0xEDB88320), one byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ d[i]) == 1'b1) begin
                r = (r >> 1) ^ 32'hEDB88320;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    assign s_ready  = (state == DATA);
    assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

    // Next-state and next-output logic; outputs describe the byte loaded at the coming edge.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        byte_cnt_nx = byte_cnt;
        crc_nx      = crc;
        tx_en_nx    = 1'b0;
        tx_er_nx    = 1'b0;
        txd_nx      = 8'h00;
        done_nx     = 1'b0;
        under_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    tx_en_nx = 1'b1;
                    txd_nx   = 8'h55;
                    cnt_nx   = 8'd1;
                    state_nx = (PREAM_LEN > 1) ? PREAM : SFD;
                end else begin
                    state_nx = IDLE;
                end
            end
            PREAM: begin
                tx_en_nx = 1'b1;
                txd_nx   = 8'h55;
                cnt_nx   = cnt + 8'd1;
                if (cnt_nx == 8'(PREAM_LEN)) begin
                    state_nx = SFD;
                end else begin
                    state_nx = PREAM;
                end
            end
            SFD: begin
                tx_en_nx    = 1'b1;
                txd_nx      = 8'hD5;
                crc_nx      = 32'hFFFFFFFF;
                byte_cnt_nx = 16'd0;
                state_nx    = DATA;
            end
            DATA: begin
                if (s_valid) begin
                    tx_en_nx    = 1'b1;
                    txd_nx      = s_data;
                    crc_nx      = crc32_byte(crc, s_data);
                    byte_cnt_nx = byte_inc;
                    cnt_nx      = 8'd0;
                    if (s_last) begin
                        if (PAD_EN && (byte_inc < MIN_LEN16)) begin
                            state_nx = PAD;
                        end else begin
                            state_nx = FCS;
                        end
                    end else begin
                        state_nx = DATA;
                    end
                end else begin
                    // Starved mid-frame: poison the frame on the wire instead of sending an FCS.
                    tx_en_nx = 1'b1;
                    tx_er_nx = 1'b1;
                    under_nx = 1'b1;
                    cnt_nx   = 8'd0;
                    state_nx = IFG;
                end
            end
`ifdef TX_PAD_EN
            PAD: begin
                tx_en_nx    = 1'b1;
                crc_nx      = crc32_byte(crc, 8'h00);
                byte_cnt_nx = byte_inc;
                if (byte_inc >= MIN_LEN16) begin
                    state_nx = FCS;
                end else begin
                    state_nx = PAD;
                end
            end
`endif
            FCS: begin
                tx_en_nx = 1'b1;
                case (cnt[1:0])
                    2'd0:    txd_nx = ~crc[7:0];
                    2'd1:    txd_nx = ~crc[15:8];
                    2'd2:    txd_nx = ~crc[23:16];
                    default: txd_nx = ~crc[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    done_nx  = 1'b1;
                    cnt_nx   = 8'd0;
                    state_nx = IFG;
                end else begin
                    cnt_nx   = cnt + 8'd1;
                    state_nx = FCS;
                end
            end
            IFG: begin
                if (cnt == 8'(IFG_LEN - 1)) begin
                    cnt_nx   = 8'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = cnt + 8'd1;
                    state_nx = IFG;
                end
            end
            default: begin
                cnt_nx   = 8'd0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters, CRC and registered PHY outputs.
    always_ff @(posedge phy_gtx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            byte_cnt   <= 16'd0;
            crc        <= 32'hFFFFFFFF;
            phy_tx_en  <= 1'b0;
            phy_tx_er  <= 1'b0;
            phy_txd    <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            byte_cnt   <= byte_cnt_nx;
            crc        <= crc_nx;
            phy_tx_en  <= tx_en_nx;
            phy_tx_er  <= tx_er_nx;
            phy_txd    <= txd_nx;
            frame_done <= done_nx;
            underrun   <= under_nx;
        end
    end
endmodule

// File: tb/tb_gmii_tx_mac.sv
// Randomized bench for gmii_tx_mac: a frame-level model predicts every output cycle.
module tb_gmii_tx_mac;
    localparam int P    = 7;
    localparam int IFG  = 12;
    localparam int MINL = 60;

    typedef logic [7:0] byte_q [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       tx_en, tx_er, done, und;
    logic [7:0] txd;

    gmii_tx_mac #(.PREAM_LEN(P), .IFG_LEN(IFG), .MIN_LEN(MINL)) dut (
        .phy_gtx_clk(clk),
        .sys_rst    (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .phy_tx_en  (tx_en),
        .phy_tx_er  (tx_er),
        .phy_txd    (txd),
        .frame_done (done),
        .underrun   (und)
    );

    always #4 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int vectors = 0;
    int errors  = 0;
    int earliest = 0;
    int last_wire = 0;
    bit chk_en = 1'b0;
    logic [12:0] exp_map [int];   // {ready, en, er, done, und, txd[7:0]}

    logic [8:0] cur_frame [$];
    logic [8:0] last_frame [$];
    bit in_frame = 1'b0;
    int gap_run = 0;
    int last_gap = 0;

    function automatic logic [12:0] mk(input bit r, input bit e, input bit er, input bit d,
                                       input bit u, input logic [7:0] b);
        return {r, e, er, d, u, b};
    endfunction

    function automatic logic [31:0] sw_crc(input byte_q q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Predict the wire image of one frame whose first byte is offered at cycle v.
    task automatic plan(input int v, input byte_q d, input int k);
        int w;
        byte_q q;
        logic [31:0] f;
        w = (v + 1 > earliest) ? v + 1 : earliest;
        for (int i = 0; i < P; i++) exp_map[w + i] = mk(0, 1, 0, 0, 0, 8'h55);
        exp_map[w + P] = mk(1, 1, 0, 0, 0, 8'hD5);
        if (k >= 0) begin
            for (int i = 0; i < k; i++) exp_map[w + P + 1 + i] = mk(1, 1, 0, 0, 0, d[i]);
            exp_map[w + P + 1 + k] = mk(0, 1, 1, 0, 1, 8'h00);
            last_wire = w + P + 1 + k;
        end else begin
            q = d;
`ifdef TX_PAD_EN
            while (q.size() < MINL) q.push_back(8'h00);
`endif
            f = sw_crc(q);
            foreach (q[i]) exp_map[w + P + 1 + i] = mk(i < d.size() - 1, 1, 0, 0, 0, q[i]);
            for (int j = 0; j < 4; j++)
                exp_map[w + P + 1 + q.size() + j] = mk(0, 1, 0, j == 3, 0, f[8*j +: 8]);
            last_wire = w + P + q.size() + 4;
        end
        earliest = last_wire + IFG + 1;
    endtask

    task automatic send(input byte_q d, input int k, input int gap);
        int n;
        bit ok;
        n = (k < 0) ? d.size() : k;
        s_valid = 1'b0;
        repeat (gap) begin
            s_data = 8'($urandom);
            s_last = 1'($urandom);
            @(posedge clk); #1;
        end
        plan(cyc, d, k);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = (k < 0) && (i == d.size() - 1);
            ok = 1'b0;
            for (int t = 0; t < 2000 && !ok; t++) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                vectors++;
                errors++;
                $display("FAIL handshake_timeout: byte %0d never accepted, expected acceptance", i);
                i = n;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (k >= 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 5000 && cyc < last_wire + 3; t++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic byte_q rand_bytes(input int n);
        byte_q q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q d, d2;
        logic [31:0] f;
        fork
            forever begin
                @(negedge clk);
                if (chk_en && !rst) begin
                    logic [12:0] e, a;
                    e = exp_map.exists(cyc) ? exp_map[cyc] : 13'd0;
                    a = {s_ready, tx_en, tx_er, done, und, txd};
                    vectors++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle %0d rdy/en/er/done/und/txd: got %b_%h, expected %b_%h",
                                 cyc, a[12:8], a[7:0], e[12:8], e[7:0]);
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (rst) begin
                    cur_frame.delete();
                    in_frame = 1'b0;
                    gap_run = 0;
                end else if (tx_en) begin
                    if (!in_frame) begin
                        last_gap = gap_run;
                        in_frame = 1'b1;
                    end
                    cur_frame.push_back({tx_er, txd});
                end else begin
                    if (in_frame) begin
                        last_frame = cur_frame;
                        cur_frame.delete();
                        in_frame = 1'b0;
                        gap_run = 0;
                    end
                    gap_run++;
                end
            end
            begin
                repeat (60000) @(posedge clk);
                $display("FAIL watchdog: simulation exceeded 60000 cycles, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_lit("reset_outputs", {26'd0, s_ready, tx_en, tx_er, done, und, |txd}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reference vector: "123456789" has CRC-32 0xCBF43926.
        d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check_lit("model_crc_check", sw_crc(d), 32'hCBF43926);
        send(d, -1, 2);
        wait_idle();
        check_lit("frame_len_123456789", last_frame.size(), 32'd21);
        if (last_frame.size() == 21) begin
            check_lit("first_pream", {23'd0, last_frame[0]},  32'h055);
            check_lit("sfd",         {23'd0, last_frame[7]},  32'h0D5);
            check_lit("fcs0",        {23'd0, last_frame[17]}, 32'h026);
            check_lit("fcs1",        {23'd0, last_frame[18]}, 32'h039);
            check_lit("fcs2",        {23'd0, last_frame[19]}, 32'h0F4);
            check_lit("fcs3",        {23'd0, last_frame[20]}, 32'h0CB);
        end

`ifdef TX_PAD_EN
        d = rand_bytes(14);
        send(d, -1, 1);
        wait_idle();
        check_lit("pad_frame_len", last_frame.size(), 32'd72);
        d2 = d;
        while (d2.size() < MINL) d2.push_back(8'h00);
        f = sw_crc(d2);
        if (last_frame.size() == 72)
            check_lit("pad_fcs", {last_frame[71][7:0], last_frame[70][7:0],
                                  last_frame[69][7:0], last_frame[68][7:0]}, f);
`endif

        // Back-to-back frames with s_valid held high through the gap.
        send(rand_bytes(9), -1, 3);
        send(rand_bytes(20), -1, 0);
        wait_idle();
        check_lit("b2b_gap", last_gap, 32'd12);

        // Underrun after byte 5 of a 20-byte frame, then an immediate next frame.
        send(rand_bytes(20), 5, 2);
        wait_idle();
        check_lit("underrun_len", last_frame.size(), 32'd14);
        if (last_frame.size() == 14)
            check_lit("underrun_er_byte", {23'd0, last_frame[13]}, 32'h100);
        send(rand_bytes(30), -1, 0);
        wait_idle();
        check_lit("underrun_gap", last_gap, 32'd12);

        // Long IDLE stall with junk on data/last.
        send(rand_bytes(64), -1, 30);
        wait_idle();

        // Reset in the middle of a frame.
        chk_en = 1'b0;
        s_valid = 1'b1;
        repeat (12) begin
            s_data = 8'($urandom);
            s_last = 1'b0;
            @(posedge clk); #1;
        end
        check_lit("pre_reset_en", {31'd0, tx_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_lit("mid_reset_outputs", {26'd0, s_ready, tx_en, tx_er, done, und, |txd}, 32'd0);
        s_valid = 1'b0;
        exp_map.delete();
        earliest = 0;
        last_wire = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(d, -1, 0);
        wait_idle();
        check_lit("post_reset_len", last_frame.size(), 32'd21);
        if (last_frame.size() == 21)
            check_lit("post_reset_fcs3", {23'd0, last_frame[20]}, 32'h0CB);

        // Randomized frames, some with underruns.
        for (int n = 0; n < 40; n++) begin
            int len, k;
            len = $urandom_range(1, 80);
            k = -1;
            if (len >= 2 && $urandom_range(0, 4) == 0) k = $urandom_range(1, len - 1);
            send(rand_bytes(len), k, $urandom_range(0, 15));
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
